// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl: 4-bit ALU operation decode plus an iterative multiply/divide
// engine owning the HI/LO registers. One multiply or divide runs at a time and
// stalls the execute path until HI/LO hold the result.
module alu_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       alu_control,
    output logic             md_stall,
    output logic             md_done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] md_rdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // ALU select codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    // Multiply/divide and HI/LO access functs
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, EXEC, FIX, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  acc_hi;     // partial product high / running remainder
    logic [WIDTH-1:0]  acc_lo;     // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0]  op_b;       // multiplicand or divisor magnitude
    logic              neg_a;
    logic              neg_b;
    logic              op_div;

    logic              rtype;
    logic              f_arith;
    logic              f_md_any;
    logic              issue;
    logic              busy;
    logic              mt_write;
    logic              op_signed;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;

    logic [WIDTH:0]    add_sum;
    logic [WIDTH:0]    rem_shl;
    logic              rem_ge;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]  quo_fix;
    logic [WIDTH-1:0]  rem_fix;
    logic              b_zero;

    // ALU operation decode, independent of the engine state
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            2'b00: alu_control = ALU_ADD;
            2'b01: alu_control = ALU_SUB;
            2'b11: alu_control = ALU_OR;
            default: begin
                case (funct)
                    6'b100000, 6'b100001: alu_control = ALU_ADD;
                    6'b100010, 6'b100011: alu_control = ALU_SUB;
                    6'b100100:            alu_control = ALU_AND;
                    6'b100101:            alu_control = ALU_OR;
                    6'b100110:            alu_control = ALU_XOR;
                    6'b100111:            alu_control = ALU_NOR;
                    6'b101010:            alu_control = ALU_SLT;
                    6'b101011:            alu_control = ALU_SLTU;
                    6'b000000:            alu_control = ALU_SLL;
                    6'b000010:            alu_control = ALU_SRL;
                    6'b000011:            alu_control = ALU_SRA;
                    default:              alu_control = ALU_ADD;
                endcase
            end
        endcase
    end

    // Instruction classification and operand magnitudes for issue
    always_comb begin
        rtype     = (alu_op == 2'b10);
        f_arith   = rtype && (funct == F_MULT || funct == F_MULTU ||
                              funct == F_DIV  || funct == F_DIVU);
        f_md_any  = f_arith || (rtype && (funct == F_MFHI || funct == F_MTHI ||
                                          funct == F_MFLO || funct == F_MTLO));
        issue     = rst_n && (state == IDLE) && instr_valid && f_arith;
        busy      = (state == EXEC) || (state == FIX);
        op_signed = (funct == F_MULT) || (funct == F_DIV);
        a_mag     = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
        b_mag     = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
        // md_stall is always low in IDLE for a move, so it need not be checked
        mt_write  = (state == IDLE) && instr_valid && rtype &&
                    (funct == F_MTHI || funct == F_MTLO);
    end

    // One iteration step and the sign-correction results
    always_comb begin
        add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : {(WIDTH+1){1'b0}});
        rem_shl  = {acc_hi, acc_lo[WIDTH-1]};
        rem_ge   = (rem_shl >= {1'b0, op_b});
        prod     = {acc_hi, acc_lo};
        prod_fix = (neg_a ^ neg_b) ? -prod : prod;
        quo_fix  = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
        rem_fix  = neg_a ? -acc_hi : acc_hi;
        b_zero   = (op_b == '0);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (issue) state_nxt = EXEC;
            EXEC: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: stall for the issuing op or any HI/LO access while busy
    always_comb begin
        md_stall = 1'b0;
        md_rdata = '0;
        if (rst_n) begin
            md_stall = issue || (busy && instr_valid && f_md_any);
            if (instr_valid && rtype && funct == F_MFHI) md_rdata = hi;
            if (instr_valid && rtype && funct == F_MFLO) md_rdata = lo;
        end
    end

    // Engine datapath, HI/LO registers and the completion flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            op_b        <= '0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            op_div      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            md_done     <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            md_done     <= (state == FIX);
            div_by_zero <= (state == FIX) && op_div && b_zero;
            case (state)
                IDLE: begin
                    if (issue) begin
                        cnt    <= '0;
                        acc_hi <= '0;
                        acc_lo <= a_mag;
                        op_b   <= b_mag;
                        neg_a  <= op_signed && rs_val[WIDTH-1];
                        neg_b  <= op_signed && rt_val[WIDTH-1];
                        op_div <= (funct == F_DIV) || (funct == F_DIVU);
                    end else if (mt_write) begin
                        if (funct == F_MTHI) hi <= rs_val;
                        else                 lo <= rs_val;
                    end
                end
                EXEC: begin
                    cnt <= cnt + 1'b1;
                    if (op_div) begin
                        // restoring division: quotient bits shift into acc_lo
                        acc_hi <= rem_ge ? (rem_shl[WIDTH-1:0] - op_b) : rem_shl[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], rem_ge};
                    end else begin
                        {acc_hi, acc_lo} <= {add_sum, acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (!op_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (b_zero) begin
                        // remainder is |dividend|; restoring its sign yields rs_val
                        hi <= rem_fix;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
